fwd_hazard_unit: RTL and testbench

- Sits in the ID stage, directly upstream of the ID-stage forwarding muxes.
- Keeps a small in-flight scoreboard that mirrors the EX, MM1, MM2 and WB pipeline slots.
- Each cycle it produces the 3-bit forwarding select for the rj and rk operands of the instruction in ID.
- Raises a load-use stall when a needed load result is not yet available, and inserts a bubble into EX while doing so.

---
 rtl/fwd_hazard_unit_pkg.sv | 22 ++
 rtl/fwd_hazard_unit_if.sv | 31 +++
 rtl/fwd_hazard_unit_fwd_sel.sv | 43 ++++
 rtl/fwd_hazard_unit.sv | 77 +++++++
 tb/tb_fwd_hazard_unit.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/fwd_hazard_unit_pkg.sv
// Shared definitions for the ID-stage forwarding/hazard unit: the forwarding
// select codes used by the ID forwarding muxes, and the scoreboard slot record.
package fwd_hazard_unit_pkg;

  localparam int REG_AW = 5;
  localparam int FWD_W  = 3;

  localparam logic [FWD_W-1:0] FWD_SRC_GR      = 3'd0;
  localparam logic [FWD_W-1:0] FWD_SRC_EX      = 3'd1;
  localparam logic [FWD_W-1:0] FWD_SRC_MM1     = 3'd2;
  localparam logic [FWD_W-1:0] FWD_SRC_MM2_REG = 3'd3;
  localparam logic [FWD_W-1:0] FWD_SRC_MM2_MEM = 3'd4;
  localparam logic [FWD_W-1:0] FWD_SRC_WB      = 3'd5;

  // Slot payload; the valid bit is kept separately so that only it is reset.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              is_load;
  } slot_t;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-stage request/response bundle between the decode stage and the hazard unit.
interface fwd_hazard_unit_if;
  import fwd_hazard_unit_pkg::*;

  logic              id_valid;
  logic [REG_AW-1:0] id_rj;
  logic [REG_AW-1:0] id_rk;
  logic              id_use_rj;
  logic              id_use_rk;
  logic [REG_AW-1:0] id_rd;
  logic              id_we;
  logic              id_is_load;
  logic              pipe_stall;
  logic              flush;
  logic [FWD_W-1:0]  fwd_ctrl_rj;
  logic [FWD_W-1:0]  fwd_ctrl_rk;
  logic              ld_use_stall;

  modport master (
    output id_valid, id_rj, id_rk, id_use_rj, id_use_rk, id_rd, id_we,
           id_is_load, pipe_stall, flush,
    input  fwd_ctrl_rj, fwd_ctrl_rk, ld_use_stall
  );

  modport slave (
    input  id_valid, id_rj, id_rk, id_use_rj, id_use_rk, id_rd, id_we,
           id_is_load, pipe_stall, flush,
    output fwd_ctrl_rj, fwd_ctrl_rk, ld_use_stall
  );

endinterface

// File: rtl/fwd_hazard_unit_fwd_sel.sv
// Priority encoder for one source operand: youngest matching slot picks the
// forwarding source; a load still in EX or MM1 requests a load-use stall.
module fwd_sel
  import fwd_hazard_unit_pkg::*;
(
  input  logic              id_valid,
  input  logic [REG_AW-1:0] src,
  input  logic              use_src,
  input  logic [3:0]        vld,
  input  slot_t [3:0]       slot,
  output logic [FWD_W-1:0]  sel,
  output logic              stall
);

  logic [3:0] hit;
  logic       active;

  // r0 is hard-wired zero, so it never matches a producer.
  assign active = id_valid & use_src & (src != '0);

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      hit[i] = active & vld[i] & slot[i].we & (slot[i].rd == src);
    end
  end

  always_comb begin
    sel   = FWD_SRC_GR;
    stall = 1'b0;
    if (hit[0]) begin
      if (slot[0].is_load) stall = 1'b1;
      else                 sel   = FWD_SRC_EX;
    end else if (hit[1]) begin
      if (slot[1].is_load) stall = 1'b1;
      else                 sel   = FWD_SRC_MM1;
    end else if (hit[2]) begin
      sel = slot[2].is_load ? FWD_SRC_MM2_MEM : FWD_SRC_MM2_REG;
    end else if (hit[3]) begin
      sel = FWD_SRC_WB;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// ID-stage forwarding and load-use hazard unit: an in-flight scoreboard
// mirroring EX/MM1/MM2/WB drives the rj/rk forwarding selects and the stall.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  fwd_hazard_unit_if.slave bus
);

  logic  vld_p0, vld_p1, vld_p2, vld_p3;
  slot_t slot_p0, slot_p1, slot_p2, slot_p3;

  logic [FWD_W-1:0] sel_rj, sel_rk;
  logic             stall_rj, stall_rk;
  logic             ld_use_stall;
  logic [3:0]       vld_all;
  slot_t [3:0]      slot_all;
  slot_t            id_slot;

  assign vld_all  = {vld_p3, vld_p2, vld_p1, vld_p0};
  assign slot_all = {slot_p3, slot_p2, slot_p1, slot_p0};
  assign id_slot  = '{rd: bus.id_rd, we: bus.id_we, is_load: bus.id_is_load};

  fwd_sel u_sel_rj (
    .id_valid (bus.id_valid),
    .src      (bus.id_rj),
    .use_src  (bus.id_use_rj),
    .vld      (vld_all),
    .slot     (slot_all),
    .sel      (sel_rj),
    .stall    (stall_rj)
  );

  fwd_sel u_sel_rk (
    .id_valid (bus.id_valid),
    .src      (bus.id_rk),
    .use_src  (bus.id_use_rk),
    .vld      (vld_all),
    .slot     (slot_all),
    .sel      (sel_rk),
    .stall    (stall_rk)
  );

  assign ld_use_stall     = ~rst & (stall_rj | stall_rk);
  assign bus.ld_use_stall = ld_use_stall;
  assign bus.fwd_ctrl_rj  = rst ? FWD_SRC_GR : sel_rj;
  assign bus.fwd_ctrl_rk  = rst ? FWD_SRC_GR : sel_rk;

  // Stage boundary ID -> EX -> MM1 -> MM2 -> WB: valid bits (control).
  // A flush kills both the instruction leaving ID and the one leaving EX;
  // a stalled ID inserts a bubble into EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
    end else if (!bus.pipe_stall) begin
      vld_p3 <= vld_p2;
      vld_p2 <= vld_p1;
      vld_p1 <= vld_p0 & ~bus.flush;
      vld_p0 <= bus.id_valid & ~ld_use_stall & ~bus.flush;
    end
  end

  // Stage boundary ID -> EX -> MM1 -> MM2 -> WB: slot payload (no reset).
  always_ff @(posedge clk) begin
    if (!bus.pipe_stall) begin
      slot_p3 <= slot_p2;
      slot_p2 <= slot_p1;
      slot_p1 <= slot_p0;
      slot_p0 <= id_slot;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed hazard scenarios followed by random
// traffic, checked against an age-based model of in-flight instructions.
module tb_fwd_hazard_unit;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fwd_hazard_unit_if bus ();

  fwd_hazard_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    bit v;
    int rd;
    bit we;
    bit ld;
  } rec_t;

  // pipe[age]: age 0 = newest (EX), 3 = oldest (WB).
  rec_t pipe [4];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // A non-load result can be forwarded from any age; a load result only once
  // the memory data exists, i.e. from MM2 (age 2) onwards.
  function automatic int find_age(input int s, input bit use_s, input bit idv);
    if (!idv || !use_s || s == 0) return -1;
    for (int a = 0; a < 4; a++)
      if (pipe[a].v && pipe[a].we && pipe[a].rd == s) return a;
    return -1;
  endfunction

  function automatic bit exp_stall(input int s, input bit use_s, input bit idv);
    int a;
    a = find_age(s, use_s, idv);
    return (a >= 0) && pipe[a].ld && (a < 2);
  endfunction

  function automatic int exp_sel(input int s, input bit use_s, input bit idv);
    int a;
    a = find_age(s, use_s, idv);
    if (a < 0) return 0;
    if (a == 3) return 5;
    if (pipe[a].ld) return (a == 2) ? 4 : 0;
    return a + 1;
  endfunction

  // One clock: apply ID inputs, check the combinational outputs mid-cycle,
  // then advance the model across the edge. e_* < 0 means no literal check.
  task automatic step(input bit v, input int rj, input int rk, input bit urj,
                      input bit urk, input int rd, input bit we, input bit ld,
                      input bit ps, input bit fl, input bit rs,
                      input int e_rj, input int e_rk, input int e_st);
    bit st_rj, st_rk, st;
    int s_rj, s_rk;
    rst            = rs;
    bus.id_valid   = v;
    bus.id_rj      = rj[4:0];
    bus.id_rk      = rk[4:0];
    bus.id_use_rj  = urj;
    bus.id_use_rk  = urk;
    bus.id_rd      = rd[4:0];
    bus.id_we      = we;
    bus.id_is_load = ld;
    bus.pipe_stall = ps;
    bus.flush      = fl;
    @(negedge clk);
    if (rs) begin
      st_rj = 0; st_rk = 0; s_rj = 0; s_rk = 0;
    end else begin
      st_rj = exp_stall(rj, urj, v);
      st_rk = exp_stall(rk, urk, v);
      s_rj  = exp_sel(rj, urj, v);
      s_rk  = exp_sel(rk, urk, v);
    end
    st = st_rj | st_rk;
    chk("stall", int'(bus.ld_use_stall), int'(st));
    if (!st_rj) chk("sel_rj", int'(bus.fwd_ctrl_rj), s_rj);
    if (!st_rk) chk("sel_rk", int'(bus.fwd_ctrl_rk), s_rk);
    if (e_rj >= 0) chk("lit_rj", int'(bus.fwd_ctrl_rj), e_rj);
    if (e_rk >= 0) chk("lit_rk", int'(bus.fwd_ctrl_rk), e_rk);
    if (e_st >= 0) chk("lit_stall", int'(bus.ld_use_stall), e_st);
    @(posedge clk);
    if (rs) begin
      for (int a = 0; a < 4; a++) pipe[a].v = 0;
    end else if (!ps) begin
      pipe[3] = pipe[2];
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[1].v = pipe[0].v & ~fl;
      pipe[0] = '{v: v & ~st & ~fl, rd: rd, we: we, ld: ld};
    end
    #1;
  endtask

  task automatic nop();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1, -1, -1);
  endtask

  initial begin
    for (int a = 0; a < 4; a++) pipe[a] = '{v: 0, rd: 0, we: 0, ld: 0};
    #1;
    // Reset: outputs forced to GR/0 while rst is high.
    step(1, 4, 4, 1, 1, 4, 1, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

    // ADD r5 forwarded from EX, then from MM1.
    step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, -1, -1, -1);
    step(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, -1, 0);
    step(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2, -1, 0);
    repeat (3) nop();

    // LD r7: two stall cycles, then MM2 memory data.
    step(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, -1, -1, -1);
    step(1, 0, 7, 0, 1, 1, 1, 0, 0, 0, 0, -1, -1, 1);
    step(1, 0, 7, 0, 1, 1, 1, 0, 0, 0, 0, -1, -1, 1);
    step(1, 0, 7, 0, 1, 1, 1, 0, 0, 0, 0, -1, 4, 0);
    repeat (3) nop();

    // r5 in WB and MM1: youngest wins. r0 in EX with we=1: never forwarded.
    step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, -1, -1, -1);
    nop();
    step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, -1, -1, -1);
    step(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, -1, -1, -1);
    step(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2, -1, 0);
    repeat (4) nop();
    step(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, -1, -1, -1);
    step(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) nop();

    // Freeze with ADD r3 in MM2: select held, slots unchanged afterwards.
    step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, -1, -1, -1);
    nop();
    nop();
    repeat (3) step(1, 3, 0, 1, 0, 0, 0, 0, 1, 0, 0, 3, -1, 0);
    step(1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3, -1, 0);
    step(1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 5, -1, 0);
    repeat (3) nop();

    // Flush with LD r9 in ID and ADD r9 in EX.
    step(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, -1, -1, -1);
    step(1, 0, 0, 0, 0, 9, 1, 1, 0, 1, 0, -1, -1, -1);
    step(1, 9, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, -1, 0);
    repeat (3) nop();
    // Flush under freeze: slots hold, ADD r9 stays in EX.
    step(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, -1, -1, -1);
    step(1, 0, 0, 0, 0, 9, 1, 1, 1, 1, 0, -1, -1, -1);
    step(1, 9, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1, -1, 0);
    repeat (3) nop();

    // Reset with all slots writing r4.
    repeat (4) step(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, -1, -1, -1);
    step(1, 4, 4, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    step(1, 4, 4, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(1, 4, 4, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Random traffic over a small register set to provoke hazards.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(3, 0) != 0, $urandom_range(3, 0), $urandom_range(3, 0),
           $urandom_range(1, 0), $urandom_range(1, 0), $urandom_range(3, 0),
           $urandom_range(3, 0) != 0, $urandom_range(2, 0) == 0,
           $urandom_range(4, 0) == 0, $urandom_range(7, 0) == 0,
           $urandom_range(47, 0) == 0, -1, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
